// File: rtl/leiwand_rv32_bus_ram.sv
// leiwand_rv32_bus_ram
// Single-port memory slave for the leiwand_rv32 core bus (valid/ready/wen).
// Supports 32- or 64-bit XLEN, a configurable depth and base address, and
// programmable wait states. Accesses that hit neither the RAM nor tohost get
// an error response. A riscv-tests style tohost register drives the
// test_done, test_pass and test_code outputs.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high
//   valid      request from the core, held until ready
//   ready      one-cycle response strobe
//   wen        byte write enables (all zero = read)
//   addr       byte address
//   wdata      write data, little-endian byte lanes
//   rdata      read data, valid while ready=1, otherwise 0
//   error      qualifies ready: access hit neither RAM nor tohost
//   test_done  sticky, set by any tohost write
//   test_pass  last tohost value was exactly 1
//   test_code  last tohost value bits [XLEN-1:1]
//
// state | meaning
// IDLE  | waiting for valid, latches the request
// WAIT  | counting down the wait states
// RESP  | ready pulse, access committed on the closing edge
// GAP   | one dead cycle so a still-held valid is not executed twice
module leiwand_rv32_bus_ram #(
  parameter int              XLEN        = 32,
  parameter int              WORDS       = 4096,
  parameter logic [XLEN-1:0] BASE_ADDR   = XLEN'(64'h8000_0000),
  parameter int              LATENCY     = 1,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(64'h8000_1000 + 64'(WORDS) * 64'(XLEN / 8)),
  parameter string           INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  output logic              ready,
  input  logic [XLEN/8-1:0] wen,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata,
  output logic              error,
  output logic              test_done,
  output logic              test_pass,
  output logic [XLEN-2:0]   test_code
);

  localparam int NB    = XLEN / 8;
  localparam int SHIFT = $clog2(NB);
  localparam int IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [3:0]    LAT     = 4'(LATENCY);
  localparam logic [XLEN:0] RAM_END = {1'b0, BASE_ADDR} + (XLEN+1)'(WORDS * NB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]      state;
  logic [3:0]      cnt;
  logic [XLEN-1:0] mem [WORDS];
  logic [XLEN-1:0] tohost_val;

  // decode of the live bus address; one bit wider so the window end cannot wrap
  logic [XLEN:0]   off_ext;
  logic            in_ram_d, tohost_d;
  logic [IDXW-1:0] idx_d;

  assign off_ext  = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign in_ram_d = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < RAM_END);
  assign idx_d    = IDXW'(off_ext >> SHIFT);
  assign tohost_d = (addr[XLEN-1:SHIFT] == TOHOST_ADDR[XLEN-1:SHIFT]);

  logic            in_ram_q, tohost_q;
  logic [IDXW-1:0] idx_q;
  logic [NB-1:0]   wen_q;
  logic [XLEN-1:0] wdata_q;

  // With zero wait states the response is built in the same edge that
  // accepts the request, so the live decode is used instead of the latch.
  logic            sel_ram, sel_th, sel_rd;
  logic [IDXW-1:0] sel_idx;
  logic            enter_resp;

  always_comb begin
    sel_ram = in_ram_q;
    sel_th  = tohost_q;
    sel_idx = idx_q;
    sel_rd  = ~|wen_q;
    if (state == S_IDLE) begin
      sel_ram = in_ram_d;
      sel_th  = tohost_d;
      sel_idx = idx_d;
      sel_rd  = ~|wen;
    end
  end

  assign enter_resp = ((state == S_IDLE) && valid && (LAT == 4'd0)) ||
                      ((state == S_WAIT) && (cnt == 4'd1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      in_ram_q <= 1'b0;
      tohost_q <= 1'b0;
      idx_q    <= '0;
      wen_q    <= '0;
      wdata_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid) begin
            in_ram_q <= in_ram_d;
            tohost_q <= tohost_d;
            idx_q    <= idx_d;
            wen_q    <= wen;
            wdata_q  <= wdata;
            cnt      <= LAT;
            state    <= (LAT == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        S_RESP:  state <= S_GAP;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready <= 1'b0;
      error <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= enter_resp;
      error <= enter_resp && !sel_ram && !sel_th;
      rdata <= '0;
      if (enter_resp && sel_rd) begin
        if (sel_ram)     rdata <= mem[sel_idx];
        else if (sel_th) rdata <= tohost_val;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tohost_val <= '0;
      test_done  <= 1'b0;
      test_pass  <= 1'b0;
      test_code  <= '0;
    end else if ((state == S_RESP) && tohost_q && (|wen_q)) begin
      tohost_val <= wdata_q;
      test_done  <= 1'b1;
      test_pass  <= (wdata_q == XLEN'(1));
      test_code  <= wdata_q[XLEN-1:1];
    end
  end

  // RAM contents survive reset; the reset check drops a write caught mid-flight.
  always_ff @(posedge clk) begin
    if (!reset && (state == S_RESP) && in_ram_q) begin
      for (int i = 0; i < NB; i++) begin
        if (wen_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_leiwand_rv32_bus_ram.sv
module tb_leiwand_rv32_bus_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rs;

  // three 32-bit instances: index 0 LATENCY=0, 1 LATENCY=3, 2 LATENCY=5
  logic [2:0]  v32, rdy32, err32, done32, pass32;
  logic [3:0]  we32 [3];
  logic [31:0] a32 [3];
  logic [31:0] wd32 [3];
  logic [31:0] rd32 [3];
  logic [30:0] code32 [3];

  logic        v64, rdy64, err64, done64, pass64;
  logic [7:0]  we64;
  logic [63:0] a64, wd64, rd64;
  logic [62:0] code64;

  int n_chk  = 0;
  int n_pass = 0;

  leiwand_rv32_bus_ram #(.XLEN(32), .LATENCY(0)) u_lat0 (
    .clk(clk), .reset(rs[0]), .valid(v32[0]), .ready(rdy32[0]), .wen(we32[0]),
    .addr(a32[0]), .wdata(wd32[0]), .rdata(rd32[0]), .error(err32[0]),
    .test_done(done32[0]), .test_pass(pass32[0]), .test_code(code32[0]));

  leiwand_rv32_bus_ram #(.XLEN(32), .LATENCY(3)) u_lat3 (
    .clk(clk), .reset(rs[1]), .valid(v32[1]), .ready(rdy32[1]), .wen(we32[1]),
    .addr(a32[1]), .wdata(wd32[1]), .rdata(rd32[1]), .error(err32[1]),
    .test_done(done32[1]), .test_pass(pass32[1]), .test_code(code32[1]));

  leiwand_rv32_bus_ram #(.XLEN(32), .LATENCY(5)) u_lat5 (
    .clk(clk), .reset(rs[2]), .valid(v32[2]), .ready(rdy32[2]), .wen(we32[2]),
    .addr(a32[2]), .wdata(wd32[2]), .rdata(rd32[2]), .error(err32[2]),
    .test_done(done32[2]), .test_pass(pass32[2]), .test_code(code32[2]));

  leiwand_rv32_bus_ram #(.XLEN(64), .LATENCY(1)) u_x64 (
    .clk(clk), .reset(rs[3]), .valid(v64), .ready(rdy64), .wen(we64),
    .addr(a64), .wdata(wd64), .rdata(rd64), .error(err64),
    .test_done(done64), .test_pass(pass64), .test_code(code64));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // k = edges after the sampling edge until ready is seen (equals LATENCY)
  task automatic req32(input int d, input logic [3:0] w, input logic [31:0] ad,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic er, output int k);
    @(negedge clk);
    v32[d] = 1'b1; we32[d] = w; a32[d] = ad; wd32[d] = wd;
    @(posedge clk); #1;
    k = 0;
    while (rdy32[d] !== 1'b1 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    rd = rd32[d];
    er = err32[d];
    @(negedge clk);
    v32[d] = 1'b0; we32[d] = '0;
    @(negedge clk);
  endtask

  task automatic req64(input logic [7:0] w, input logic [63:0] ad, input logic [63:0] wd,
                       output logic [63:0] rd, output logic er, output int k);
    @(negedge clk);
    v64 = 1'b1; we64 = w; a64 = ad; wd64 = wd;
    @(posedge clk); #1;
    k = 0;
    while (rdy64 !== 1'b1 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    rd = rd64;
    er = err64;
    @(negedge clk);
    v64 = 1'b0; we64 = '0;
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic [63:0] rdw;
  logic        er;
  int          k;
  int          pulses;

  initial begin
    rs = 4'hF;
    v32 = '0; v64 = 1'b0; we64 = '0; a64 = '0; wd64 = '0;
    for (int i = 0; i < 3; i++) begin
      we32[i] = '0; a32[i] = '0; wd32[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_ready",  64'(rdy32[0]), 64'd0);
    check("rst_error",  64'(err32[0]), 64'd0);
    check("rst_rdata",  64'(rd32[0]), 64'd0);
    check("rst_done",   64'(done32[0]), 64'd0);
    check("rst_pass",   64'(pass32[0]), 64'd0);
    check("rst_code",   64'(code32[0]), 64'd0);
    check("rst_rdata64", rd64, 64'd0);
    rs = 4'h0;

    // LATENCY=0 write / read back
    req32(0, 4'hF, 32'h8000_0010, 32'hDEAD_BEEF, rd, er, k);
    check("l0_wr_lat", 64'(k), 64'd0);
    check("l0_wr_err", 64'(er), 64'd0);
    check("l0_wr_rdata", 64'(rd), 64'd0);
    req32(0, 4'h0, 32'h8000_0010, 32'h0, rd, er, k);
    check("l0_rd_lat", 64'(k), 64'd0);
    check("l0_rd_data", 64'(rd), 64'hDEAD_BEEF);
    check("l0_rd_err", 64'(er), 64'd0);

    // byte lanes
    req32(0, 4'hF, 32'h8000_0020, 32'h1122_3344, rd, er, k);
    req32(0, 4'b0101, 32'h8000_0020, 32'hAABB_CCDD, rd, er, k);
    req32(0, 4'h0, 32'h8000_0020, 32'h0, rd, er, k);
    check("lanes_rd", 64'(rd), 64'h11BB_33DD);

    // tohost at 0x80001000 + 4096*4
    req32(0, 4'hF, 32'h8000_5000, 32'h1, rd, er, k);
    check("th1_err", 64'(er), 64'd0);
    check("th1_done", 64'(done32[0]), 64'd1);
    check("th1_pass", 64'(pass32[0]), 64'd1);
    check("th1_code", 64'(code32[0]), 64'd0);
    req32(0, 4'hF, 32'h8000_5000, 32'h2B, rd, er, k);
    check("th2_done", 64'(done32[0]), 64'd1);
    check("th2_pass", 64'(pass32[0]), 64'd0);
    check("th2_code", 64'(code32[0]), 64'h15);
    req32(0, 4'h0, 32'h8000_5000, 32'h0, rd, er, k);
    check("th_rd", 64'(rd), 64'h2B);
    check("th_rd_err", 64'(er), 64'd0);

    // LATENCY=3
    req32(1, 4'hF, 32'h8000_0000, 32'h5A5A_5A5A, rd, er, k);
    check("l3_wr_lat", 64'(k), 64'd3);
    // hold valid past ready: the gap cycle must not respond again
    @(negedge clk);
    v32[1] = 1'b1; we32[1] = 4'h0; a32[1] = 32'h8000_0000;
    @(posedge clk); #1;
    k = 0;
    while (rdy32[1] !== 1'b1 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("l3_rd_lat", 64'(k), 64'd3);
    check("l3_rd_data", 64'(rd32[1]), 64'h5A5A_5A5A);
    @(posedge clk); #1;
    check("l3_gap_ready", 64'(rdy32[1]), 64'd0);
    @(negedge clk);
    v32[1] = 1'b0;
    @(posedge clk); #1;
    check("l3_idle_ready", 64'(rdy32[1]), 64'd0);

    // out of range: one word past the end (aliases word 0 in the index) and below base
    req32(1, 4'hF, 32'h8000_4000, 32'hFFFF_FFFF, rd, er, k);
    check("oor_hi_err", 64'(er), 64'd1);
    check("oor_hi_rdata", 64'(rd), 64'd0);
    req32(1, 4'hF, 32'h7FFF_FFFC, 32'hFFFF_FFFF, rd, er, k);
    check("oor_lo_err", 64'(er), 64'd1);
    req32(1, 4'h0, 32'h7FFF_FFFC, 32'h0, rd, er, k);
    check("oor_lo_rd_err", 64'(er), 64'd1);
    check("oor_lo_rd_rdata", 64'(rd), 64'd0);
    req32(1, 4'h0, 32'h8000_0000, 32'h0, rd, er, k);
    check("oor_mem_kept", 64'(rd), 64'h5A5A_5A5A);
    check("oor_mem_err", 64'(er), 64'd0);

    // LATENCY=5: reset during WAIT of a write
    req32(2, 4'hF, 32'h8000_5000, 32'h1, rd, er, k);
    check("l5_th_done", 64'(done32[2]), 64'd1);
    req32(2, 4'hF, 32'h8000_0040, 32'h1234_5678, rd, er, k);
    check("l5_wr_lat", 64'(k), 64'd5);
    @(negedge clk);
    v32[2] = 1'b1; we32[2] = 4'hF; a32[2] = 32'h8000_0040; wd32[2] = 32'hCAFE_F00D;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rs[2] = 1'b1;
    v32[2] = 1'b0; we32[2] = '0;
    #1;
    check("rst5_ready", 64'(rdy32[2]), 64'd0);
    check("rst5_done", 64'(done32[2]), 64'd0);
    check("rst5_pass", 64'(pass32[2]), 64'd0);
    check("rst5_rdata", 64'(rd32[2]), 64'd0);
    check("rst5_error", 64'(err32[2]), 64'd0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdy32[2] === 1'b1) pulses++;
    end
    rs[2] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rdy32[2] === 1'b1) pulses++;
    end
    check("rst5_no_ready", 64'(pulses), 64'd0);
    req32(2, 4'h0, 32'h8000_0040, 32'h0, rd, er, k);
    check("rst5_after_lat", 64'(k), 64'd5);
    check("rst5_word_kept", 64'(rd), 64'h1234_5678);

    // XLEN=64, LATENCY=1
    req64(8'hFF, 64'h8000_0008, 64'h0, rdw, er, k);
    req64(8'hF0, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, rdw, er, k);
    check("x64_wr_lat", 64'(k), 64'd1);
    req64(8'h00, 64'h8000_0008, 64'h0, rdw, er, k);
    check("x64_rd", rdw, 64'h0123_4567_0000_0000);
    check("x64_rd_err", 64'(er), 64'd0);
    req64(8'h00, 64'h8000_000C, 64'h0, rdw, er, k);
    check("x64_rd_unaligned", rdw, 64'h0123_4567_0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
